// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the serial pattern detector.
package seq_det_pkg;

  // Externally visible 2-bit FSM state encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,  // unconfigured, input ignored
    ST_FILL = 2'b01,  // window not yet long enough to complete
    ST_HUNT = 2'b10,  // next accepted bit can complete a match
    ST_HIT  = 2'b11   // last accepted bit completed a match
  } state_t;

  // Widest pattern the mask helper can describe
  localparam int unsigned MASK_MAX_W = 64;

  // Low 'len' bits set; callers truncate to their pattern width
  function automatic logic [MASK_MAX_W-1:0] len_mask(input int unsigned len);
    logic [MASK_MAX_W-1:0] m;
    if (len >= MASK_MAX_W) begin
      m = '1;
    end else begin
      m = (MASK_MAX_W'(1) << len) - MASK_MAX_W'(1);
    end
    return m;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; a clear coinciding with an increment yields 1.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: clear has priority but still credits a same-cycle increment
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = inc_i ? CNT_W'(1) : '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Count register, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/seq_pattern_detector.sv
// Runtime-programmable serial pattern detector with overlap control,
// registered match pulse, saturating match counter and visible FSM state.
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int unsigned PAT_W = 8,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  output logic             cfg_err,
  input  logic             inp_valid,
  input  logic             inp,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  input  logic             cnt_clr,
  output logic [1:0]       outputState
);

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovl_q, ovl_d;
  logic [PAT_W-2:0] sh_q, sh_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic             match_q, match_d;
  logic             cfg_err_q, cfg_err_d;

  logic             cfg_legal;
  logic             accept;
  logic             hit;
  logic [PAT_W-1:0] window;
  logic [PAT_W-1:0] mask;
  logic [LEN_W-1:0] len_m1;
  logic [LEN_W-1:0] fill_inc;

  // Comparator and helper terms; cfg_we always wins over a data bit
  always_comb begin
    cfg_legal = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));
    accept    = inp_valid && !cfg_we && (state_q != ST_IDLE);
    window    = {sh_q, inp};
    mask      = PAT_W'(len_mask(32'(len_q)));
    len_m1    = len_q - LEN_W'(1);
    fill_inc  = (fill_q >= len_q) ? len_q : (fill_q + LEN_W'(1));
    hit       = accept && (fill_q >= len_m1) && ((window & mask) == (pat_q & mask));
  end

  // Next-state, config, history and pulse logic
  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    len_d     = len_q;
    ovl_d     = ovl_q;
    sh_d      = sh_q;
    fill_d    = fill_q;
    match_d   = 1'b0;
    cfg_err_d = 1'b0;
    if (cfg_we) begin
      if (cfg_legal) begin
        pat_d   = cfg_pattern;
        len_d   = cfg_len;
        ovl_d   = cfg_overlap;
        sh_d    = '0;
        fill_d  = '0;
        state_d = (cfg_len == LEN_W'(1)) ? ST_HUNT : ST_FILL;
      end else begin
        cfg_err_d = 1'b1;
      end
    end else if (accept) begin
      if (hit) begin
        match_d = 1'b1;
        state_d = ST_HIT;
        if (ovl_q) begin
          fill_d = len_q;
          sh_d   = window[PAT_W-2:0];
        end else begin
          fill_d = '0;
          sh_d   = '0;
        end
      end else begin
        fill_d  = fill_inc;
        sh_d    = window[PAT_W-2:0];
        state_d = (fill_inc >= len_m1) ? ST_HUNT : ST_FILL;
      end
    end else if (state_q == ST_HIT) begin
      state_d = (fill_q >= len_m1) ? ST_HUNT : ST_FILL;
    end
  end

  // State, config and output registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      ovl_q     <= 1'b0;
      sh_q      <= '0;
      fill_q    <= '0;
      match_q   <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      ovl_q     <= ovl_d;
      sh_q      <= sh_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (hit),
    .clr_i   (cnt_clr),
    .count_o (match_cnt)
  );

  assign match       = match_q;
  assign cfg_err     = cfg_err_q;
  assign outputState = state_q;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Scoreboard bench for seq_pattern_detector (PAT_W=8, CNT_W=2).
module tb_seq_pattern_detector;

  localparam int unsigned PAT_W = 8;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned LEN_W = 4;

  logic             clk;
  logic             rst;
  logic             cfg_we;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_overlap;
  logic             cfg_err;
  logic             inp_valid;
  logic             inp;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_clr;
  logic [1:0]       outputState;

  seq_pattern_detector #(
    .PAT_W (PAT_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_err     (cfg_err),
    .inp_valid   (inp_valid),
    .inp         (inp),
    .match       (match),
    .match_cnt   (match_cnt),
    .cnt_clr     (cnt_clr),
    .outputState (outputState)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       m;
    logic [1:0] st;
    logic [1:0] cnt;
    logic       err;
    int         id;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   step_id = 0;

  // Monitor: after every edge, retire the oldest expectation against the outputs
  always @(posedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (match !== e.m) begin
        n_bad++;
        $display("FAIL step%0d match: got %0d expected %0d", e.id, match, e.m);
      end
      n_cmp++;
      if (outputState !== e.st) begin
        n_bad++;
        $display("FAIL step%0d state: got %0d expected %0d", e.id, outputState, e.st);
      end
      n_cmp++;
      if (match_cnt !== e.cnt) begin
        n_bad++;
        $display("FAIL step%0d match_cnt: got %0d expected %0d", e.id, match_cnt, e.cnt);
      end
      n_cmp++;
      if (cfg_err !== e.err) begin
        n_bad++;
        $display("FAIL step%0d cfg_err: got %0d expected %0d", e.id, cfg_err, e.err);
      end
    end
  end

  // One clock of stimulus plus the outputs expected right after that edge
  task automatic step(input logic r, input logic we, input logic [7:0] pat,
                      input logic [3:0] len, input logic ovl, input logic v,
                      input logic d, input logic clr, input logic em,
                      input logic [1:0] est, input logic [1:0] ecnt, input logic eerr);
    exp_t x;
    rst         = r;
    cfg_we      = we;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    inp_valid   = v;
    inp         = d;
    cnt_clr     = clr;
    step_id++;
    x.m = em; x.st = est; x.cnt = ecnt; x.err = eerr; x.id = step_id;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  // Accepted data bit, no config, no clear
  task automatic bit_in(input logic d, input logic em, input logic [1:0] est,
                        input logic [1:0] ecnt);
    step(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, d, 1'b0, em, est, ecnt, 1'b0);
  endtask

  initial begin
    // Reset state
    step(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 1'b0);
    step(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'd0, 1'b0);

    // Unconfigured: ones are ignored
    for (int i = 0; i < 4; i++) bit_in(1'b1, 1'b0, 2'b00, 2'd0);

    // len=3, 101, overlapping
    step(1'b0, 1'b1, 8'b101, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'd0, 1'b0);
    bit_in(1'b1, 1'b0, 2'b01, 2'd0);
    bit_in(1'b0, 1'b0, 2'b10, 2'd0);
    bit_in(1'b1, 1'b1, 2'b11, 2'd1);
    bit_in(1'b0, 1'b0, 2'b10, 2'd1);
    bit_in(1'b1, 1'b1, 2'b11, 2'd2);
    step(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'd2, 1'b0);
    step(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'd0, 1'b0);

    // len=3, 101, non-overlapping
    step(1'b0, 1'b1, 8'b101, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'd0, 1'b0);
    bit_in(1'b1, 1'b0, 2'b01, 2'd0);
    bit_in(1'b0, 1'b0, 2'b10, 2'd0);
    bit_in(1'b1, 1'b1, 2'b11, 2'd1);
    bit_in(1'b0, 1'b0, 2'b01, 2'd1);
    bit_in(1'b1, 1'b0, 2'b10, 2'd1);

    // Illegal lengths: one-cycle error pulse, config untouched
    step(1'b0, 1'b1, 8'hFF, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'd1, 1'b1);
    step(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'd1, 1'b0);
    step(1'b0, 1'b1, 8'hFF, 4'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 2'd1, 1'b1);
    step(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'd1, 1'b0);
    // Old 101 config still active: history 01, then 0,1 completes 101
    bit_in(1'b0, 1'b0, 2'b10, 2'd1);
    bit_in(1'b1, 1'b1, 2'b11, 2'd2);

    // cfg_we with a valid bit: bit dropped, window restarts empty
    step(1'b0, 1'b1, 8'b11, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 2'd2, 1'b0);
    bit_in(1'b1, 1'b0, 2'b10, 2'd2);
    bit_in(1'b1, 1'b1, 2'b11, 2'd3);

    // len=1 pattern 1; config write with clear, then saturation
    step(1'b0, 1'b1, 8'b1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'd0, 1'b0);
    bit_in(1'b1, 1'b1, 2'b11, 2'd1);
    bit_in(1'b1, 1'b1, 2'b11, 2'd2);
    bit_in(1'b1, 1'b1, 2'b11, 2'd3);
    bit_in(1'b1, 1'b1, 2'b11, 2'd3);
    bit_in(1'b1, 1'b1, 2'b11, 2'd3);
    // Clear together with a hit leaves one
    step(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 2'd1, 1'b0);
    bit_in(1'b0, 1'b0, 2'b10, 2'd1);
    step(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'd0, 1'b0);

    // Reset two bits into a three-bit match
    step(1'b0, 1'b1, 8'b101, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'd0, 1'b0);
    bit_in(1'b1, 1'b0, 2'b01, 2'd0);
    bit_in(1'b0, 1'b0, 2'b10, 2'd0);
    step(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'd0, 1'b0);
    bit_in(1'b1, 1'b0, 2'b00, 2'd0);
    bit_in(1'b0, 1'b0, 2'b00, 2'd0);
    bit_in(1'b1, 1'b0, 2'b00, 2'd0);
    // Reconfigure, match again; a later config write keeps the count
    step(1'b0, 1'b1, 8'b101, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'd0, 1'b0);
    bit_in(1'b1, 1'b0, 2'b01, 2'd0);
    bit_in(1'b0, 1'b0, 2'b10, 2'd0);
    bit_in(1'b1, 1'b1, 2'b11, 2'd1);
    step(1'b0, 1'b1, 8'b110, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'd1, 1'b0);

    // Drain: every expectation must have been retired
    step(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'd1, 1'b0);
    repeat (2) @(posedge clk);
    #5;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
